// File: rtl/boot_rom_copier_pkg.sv
// Shared types and constants for the boot ROM to instruction RAM copier.
package boot_copy_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [3:0] RAM_BE_ALL = 4'hF;

endpackage

// File: rtl/boot_rom_copier.sv
// Copies NUM_WORDS words from a 1-cycle-latency boot ROM into instruction RAM over a
// req/gnt write port, then raises fetch enable for the core.
module boot_rom_copier
    import boot_copy_pkg::*;
#(
    parameter int unsigned           ROM_AW    = 10,
    parameter int unsigned           NUM_WORDS = 800,
    parameter int unsigned           RAM_AW    = 32,
    parameter logic [RAM_AW-1:0]     RAM_BASE  = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start_i,
    output logic              rom_csn_o,
    output logic [ROM_AW-1:0] rom_a_o,
    input  logic [31:0]       rom_q_i,
    output logic              ram_req_o,
    output logic              ram_we_o,
    output logic [3:0]        ram_be_o,
    output logic [RAM_AW-1:0] ram_addr_o,
    output logic [31:0]       ram_wdata_o,
    input  logic              ram_gnt_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              fetch_enable_o,
    output logic [31:0]       checksum_o
);

    // One extra index bit so NUM_WORDS == 2**ROM_AW never wraps the counter.
    localparam int unsigned        IDX_W    = ROM_AW + 1;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_WORDS - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      checksum_q, checksum_d;
    logic             last_w;

    assign last_w = (idx_q == LAST_IDX);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            checksum_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            checksum_q <= checksum_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        checksum_d = checksum_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    idx_d      = '0;
                    checksum_d = '0;
                    state_d    = RD;
                end
            end
            RD: state_d = WR;
            WR: begin
                if (ram_gnt_i) begin
                    checksum_d = checksum_q ^ rom_q_i;
                    if (last_w) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            DONE: state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Accepting a non-final word issues the next ROM read in the same cycle,
    // which keeps the copy at one word per cycle while gnt stays high.
    always_comb begin
        rom_csn_o   = 1'b1;
        rom_a_o     = '0;
        ram_req_o   = 1'b0;
        ram_be_o    = '0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        case (state_q)
            RD: begin
                rom_csn_o = 1'b0;
                rom_a_o   = ROM_AW'(idx_q);
            end
            WR: begin
                ram_req_o   = 1'b1;
                ram_be_o    = RAM_BE_ALL;
                ram_addr_o  = RAM_BASE + RAM_AW'({idx_q, 2'b00});
                ram_wdata_o = rom_q_i;
                rom_a_o     = ROM_AW'(idx_q);
                if (ram_gnt_i && !last_w) begin
                    rom_csn_o = 1'b0;
                    rom_a_o   = ROM_AW'(idx_q + IDX_W'(1));
                end
            end
            default: ;
        endcase
    end

    assign ram_we_o       = ram_req_o;
    assign busy_o         = (state_q == RD) || (state_q == WR);
    assign done_o         = (state_q == DONE);
    assign fetch_enable_o = done_o;
    assign checksum_o     = checksum_q;

endmodule

// File: tb/tb_boot_rom_copier.sv
// Self-checking bench for boot_rom_copier: three parameterisations checked against a
// transaction-level copy model every cycle, plus hand-computed literal expectations.
module tb_boot_rom_copier;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start [3];
    logic        gnt   [3];
    logic        csn   [3];
    logic [9:0]  ra    [3];
    logic [31:0] rq    [3];
    logic        req   [3];
    logic        we    [3];
    logic [3:0]  be    [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic        busy  [3];
    logic        done  [3];
    logic        fe    [3];
    logic [31:0] csum  [3];

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 0;
    bit rand_gnt = 0;

    always #5 CLK = ~CLK;

    boot_rom_copier u_def (
        .CLK(CLK), .RST(RST), .start_i(start[0]),
        .rom_csn_o(csn[0]), .rom_a_o(ra[0]), .rom_q_i(rq[0]),
        .ram_req_o(req[0]), .ram_we_o(we[0]), .ram_be_o(be[0]),
        .ram_addr_o(addr[0]), .ram_wdata_o(wdata[0]), .ram_gnt_i(gnt[0]),
        .busy_o(busy[0]), .done_o(done[0]), .fetch_enable_o(fe[0]), .checksum_o(csum[0])
    );

    boot_rom_copier #(.NUM_WORDS(1), .RAM_BASE(32'h0010_0000)) u_one (
        .CLK(CLK), .RST(RST), .start_i(start[1]),
        .rom_csn_o(csn[1]), .rom_a_o(ra[1]), .rom_q_i(rq[1]),
        .ram_req_o(req[1]), .ram_we_o(we[1]), .ram_be_o(be[1]),
        .ram_addr_o(addr[1]), .ram_wdata_o(wdata[1]), .ram_gnt_i(gnt[1]),
        .busy_o(busy[1]), .done_o(done[1]), .fetch_enable_o(fe[1]), .checksum_o(csum[1])
    );

    boot_rom_copier #(.NUM_WORDS(1024)) u_full (
        .CLK(CLK), .RST(RST), .start_i(start[2]),
        .rom_csn_o(csn[2]), .rom_a_o(ra[2]), .rom_q_i(rq[2]),
        .ram_req_o(req[2]), .ram_we_o(we[2]), .ram_be_o(be[2]),
        .ram_addr_o(addr[2]), .ram_wdata_o(wdata[2]), .ram_gnt_i(gnt[2]),
        .busy_o(busy[2]), .done_o(done[2]), .fetch_enable_o(fe[2]), .checksum_o(csum[2])
    );

    function automatic logic [31:0] rom_word(input int unsigned i);
        if (i == 0)  return 32'h0000_0013;
        if (i == 31) return 32'h0100_006F;
        return (32'h9E37_79B9 * (i + 1)) ^ (i << 7);
    endfunction

    function automatic int unsigned num_words(input int k);
        return (k == 0) ? 800 : (k == 1) ? 1 : 1024;
    endfunction

    function automatic logic [31:0] ram_base(input int k);
        return (k == 1) ? 32'h0010_0000 : 32'h0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Boot ROM: registered address, data valid the cycle after csn low, held otherwise.
    always @(posedge CLK) begin
        for (int k = 0; k < 3; k++)
            if (csn[k] === 1'b0) rq[k] <= rom_word(ra[k]);
    end

    initial begin
        int unsigned stall;
        stall = 0;
        gnt[0] = 1'b1; gnt[1] = 1'b1; gnt[2] = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            if (!rand_gnt) gnt[0] = 1'b1;
            else if (stall > 0) begin
                gnt[0] = 1'b0;
                stall--;
            end else begin
                gnt[0] = 1'b1;
                stall = $urandom_range(0, 5);
            end
        end
    end

    // Copy model: a copy is a read-setup cycle followed by NUM_WORDS accepted writes.
    bit          m_act  [3];
    bit          m_rd   [3];
    bit          m_done [3];
    int unsigned m_n    [3];
    logic [31:0] m_csum [3];
    int unsigned wr_cnt [3];
    logic [31:0] img0   [1024];

    always @(posedge CLK or posedge RST) begin
        for (int k = 0; k < 3; k++) begin
            if (RST) begin
                m_act[k] = 0; m_rd[k] = 0; m_done[k] = 0; m_n[k] = 0; m_csum[k] = '0;
            end else begin
                if (req[k] === 1'b1 && gnt[k]) begin
                    wr_cnt[k]++;
                    if (k == 0) img0[(addr[0] >> 2) & 32'h3FF] = wdata[0];
                end
                if (m_act[k]) begin
                    if (m_rd[k]) m_rd[k] = 0;
                    else if (gnt[k]) begin
                        m_csum[k] ^= rom_word(m_n[k]);
                        m_n[k]++;
                        if (m_n[k] == num_words(k)) begin
                            m_act[k] = 0;
                            m_done[k] = 1;
                        end
                    end
                end else if (!m_done[k] && start[k]) begin
                    m_act[k] = 1; m_rd[k] = 1; m_n[k] = 0; m_csum[k] = '0;
                end
            end
        end
    end

    logic        p_req   [3];
    logic        p_gnt   [3];
    logic [31:0] p_addr  [3];
    logic [31:0] p_wdata [3];
    int          bad_a1 = 0;
    int          stalls = 0;

    always @(negedge CLK) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                bit exp_req, exp_csn;
                exp_req = m_act[k] && !m_rd[k];
                exp_csn = !(m_rd[k] || (exp_req && gnt[k] && (m_n[k] != num_words(k) - 1)));
                chk("busy", 32'(busy[k]), 32'(m_act[k]));
                chk("done", 32'(done[k]), 32'(m_done[k]));
                chk("fetch_en", 32'(fe[k]), 32'(m_done[k]));
                chk("req", 32'(req[k]), 32'(exp_req));
                chk("we", 32'(we[k]), 32'(exp_req));
                chk("be", 32'(be[k]), exp_req ? 32'hF : 32'h0);
                chk("csn", 32'(csn[k]), 32'(exp_csn));
                chk("checksum", csum[k], m_csum[k]);
                if (exp_req) begin
                    chk("addr", addr[k], ram_base(k) + 32'(m_n[k] * 4));
                    chk("wdata", wdata[k], rom_word(m_n[k]));
                end
                if (!exp_csn)
                    chk("rom_a", 32'(ra[k]), m_rd[k] ? 32'(m_n[k]) : 32'(m_n[k] + 1));
                if (p_req[k] && !p_gnt[k] && req[k]) begin
                    chk("stall_addr", addr[k], p_addr[k]);
                    chk("stall_wdata", wdata[k], p_wdata[k]);
                    if (k == 0) stalls++;
                end
                p_req[k] = req[k]; p_gnt[k] = gnt[k]; p_addr[k] = addr[k]; p_wdata[k] = wdata[k];
            end
            if (ra[1] !== 10'd0) bad_a1++;
        end
    end

    initial begin
        int unsigned base0, cyc, bad;
        logic [31:0] xsum;
        RST = 1'b1;
        for (int k = 0; k < 3; k++) start[k] = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_csn", 32'(csn[k]), 32'd1);
            chk("rst_req", 32'(req[k]), 32'd0);
            chk("rst_addr", addr[k], 32'd0);
            chk("rst_busy", 32'(busy[k]), 32'd0);
            chk("rst_done", 32'(done[k]), 32'd0);
            chk("rst_csum", csum[k], 32'd0);
        end
        RST = 1'b0;
        chk_en = 1;
        tick();

        // Defaults, single word and full-ROM copies in parallel, gnt tied high.
        for (int k = 0; k < 3; k++) start[k] = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) start[k] = 1'b0;
        for (int c = 2; c <= 1030; c++) begin
            tick();
            if (c == 2) begin
                chk("t1_w0_addr", addr[0], 32'h0);
                chk("t1_w0_data", wdata[0], 32'h0000_0013);
                chk("t3_req", 32'(req[1]), 32'd1);
                chk("t3_addr", addr[1], 32'h0010_0000);
            end
            if (c == 3) begin
                chk("t3_done", 32'(done[1]), 32'd1);
                chk("t3_req_after", 32'(req[1]), 32'd0);
            end
            if (c == 33) begin
                chk("t1_w31_addr", addr[0], 32'h7C);
                chk("t1_w31_data", wdata[0], 32'h0100_006F);
            end
            if (c == 801) chk("t1_done_801", 32'(done[0]), 32'd0);
            if (c == 802) begin
                chk("t1_done_802", 32'(done[0]), 32'd1);
                chk("t1_fe_802", 32'(fe[0]), 32'd1);
            end
            if (c == 1025) begin
                chk("t6_last_addr", addr[2], 32'h0000_0FFC);
                chk("t6_last_req", 32'(req[2]), 32'd1);
            end
            if (c == 1026) chk("t6_done", 32'(done[2]), 32'd1);
        end
        chk("t1_count", wr_cnt[0], 32'd800);
        chk("t3_count", wr_cnt[1], 32'd1);
        chk("t6_count", wr_cnt[2], 32'd1024);
        chk("t3_rom_a_zero", 32'(bad_a1), 32'd0);

        // Random gnt stalls.
        RST = 1'b1;
        tick();
        RST = 1'b0;
        rand_gnt = 1;
        base0 = wr_cnt[0];
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        cyc = 0;
        while (done[0] !== 1'b1 && cyc < 6000) begin
            tick();
            cyc++;
        end
        chk("t2_done_in_budget", 32'(done[0]), 32'd1);
        rand_gnt = 0;
        xsum = '0;
        bad = 0;
        for (int unsigned i = 0; i < 800; i++) begin
            xsum ^= rom_word(i);
            if (img0[i] !== rom_word(i)) bad++;
        end
        chk("t2_checksum", csum[0], xsum);
        chk("t2_image_bad_words", bad, 32'd0);
        chk("t2_count", wr_cnt[0] - base0, 32'd800);
        chk("t2_saw_stalls", 32'(stalls > 0), 32'd1);

        // Reset during word 100, then restart; start pulses in WR and DONE ignored.
        RST = 1'b1;
        tick();
        RST = 1'b0;
        base0 = wr_cnt[0];
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        repeat (101) tick();
        chk("t4_pre_req", 32'(req[0]), 32'd1);
        chk("t4_pre_addr", addr[0], 32'h190);
        chk("t4_pre_count", wr_cnt[0] - base0, 32'd100);
        RST = 1'b1;
        #1;
        chk("t4_rst_req", 32'(req[0]), 32'd0);
        chk("t4_rst_we", 32'(we[0]), 32'd0);
        chk("t4_rst_be", 32'(be[0]), 32'd0);
        chk("t4_rst_csn", 32'(csn[0]), 32'd1);
        chk("t4_rst_rom_a", 32'(ra[0]), 32'd0);
        chk("t4_rst_addr", addr[0], 32'd0);
        chk("t4_rst_wdata", wdata[0], 32'd0);
        chk("t4_rst_busy", 32'(busy[0]), 32'd0);
        chk("t4_rst_csum", csum[0], 32'd0);
        tick();
        tick();
        RST = 1'b0;
        tick();
        base0 = wr_cnt[0];
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        tick();
        chk("t4_re_addr", addr[0], 32'h0);
        chk("t4_re_data", wdata[0], 32'h0000_0013);
        for (int c = 3; c <= 815; c++) begin
            tick();
            if (c == 10 || c == 805) start[0] = 1'b1;
            if (c == 11 || c == 806) start[0] = 1'b0;
        end
        chk("t5_count", wr_cnt[0] - base0, 32'd800);
        chk("t5_done", 32'(done[0]), 32'd1);
        chk("t5_busy", 32'(busy[0]), 32'd0);
        chk("t5_req", 32'(req[0]), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
